uart_tx_queue: RTL and testbench
================================

Name: uart_tx_queue

Overview:
- Byte queue that sits directly upstream of the UART top-level transmit input (dintx/newd/donetx).
- Buffers bytes written by a host at full clk rate in a circular FIFO.
- Launches one byte at a time into the UART transmitter, holding newd long enough for the slower UART bit clock to sample it.
- Waits for transmit completion, then inserts an optional idle gap before the next byte.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..256.
- NEWD_CYCLES, 104, clk cycles newd is held high per launch (≥ one UART bit-clock period; 1 MHz / 9600 ≈ 104).
- GAP_CYCLES, 0, idle clk cycles after each donetx before the next launch; 0 means no gap state.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  host push strobe
- wr_data  in  8  host byte
- full  out  1  FIFO holds DEPTH entries
- empty  out  1  FIFO holds 0 entries
- overflow  out  1  sticky; set by a push while full; cleared only by rst
- busy  out  1  FSM not in IDLE
- dintx  out  8  byte to UART transmitter
- newd  out  1  launch request to UART transmitter
- donetx  in  1  UART transmit-complete indication (level or pulse)

Behaviour:
- Reset (async assert, sync deassert to clk):
  - full=0, empty=1, overflow=0, busy=0, dintx=8'h00, newd=0.
  - Pointers and count cleared, FSM set to IDLE.
  - Reset mid-transmission discards all queued bytes and drops newd immediately.
- Storage:
  - Count register is $clog2(DEPTH)+1 bits wide.
  - Read and write pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - full and empty are registered and derived from the count.
- Push: wr_en=1 and full=0 writes wr_data at the write pointer; count+1 on the next edge.
- Push while full: data dropped, pointers unchanged, overflow set on the next edge.
- Pop occurs only on the IDLE→LAUNCH transition.
- Simultaneous push and pop: count unchanged, both pointers advance.
  - If full at that same edge, the push is still rejected, because full is evaluated before the pop.
- donetx edge detect:
  - One-stage register done_q; done_rise = donetx & ~done_q.
  - Only rising edges count, so a level-held donetx does not retrigger.
- FSM states:
  - IDLE: busy=0. If empty=0: load dintx from the read pointer, pop, go to LAUNCH.
  - LAUNCH: newd=1; hold counter runs 0..NEWD_CYCLES-1. At the end: newd=0, go to WAIT_DONE.
    - done_rise during LAUNCH is recorded; the FSM then skips WAIT_DONE and goes to GAP/IDLE after the hold completes.
  - WAIT_DONE: newd=0, dintx held stable. On done_rise go to GAP (GAP_CYCLES>0) or IDLE.
  - GAP: counter runs 0..GAP_CYCLES-1, then IDLE.
- Latency and stability:
  - First write into an empty idle queue → newd high 2 clk cycles after the wr_en edge (1 cycle to update empty, 1 cycle for the IDLE decision).
  - dintx changes only on the IDLE→LAUNCH transition; it is stable from LAUNCH entry until the next launch.
- No timeout: a missing donetx leaves the block in WAIT_DONE until rst.

Optional Feature:
- Macro: UART_TXQ_DROP_CNT_EN.
- Defined:
  - Extra output port drop_cnt [7:0].
  - Increments on every rejected push, saturates at 8'hFF, reset to 0.
- Undefined: port and counter absent; overflow flag behaviour unchanged.

Test Plan:
- Single byte, GAP_CYCLES=0:
  - Stimulus: push 8'hA5 with block idle.
  - Required: newd rises 2 cycles later; dintx=8'hA5; newd stays high for exactly 104 cycles.
  - After loopback donetx pulse: busy=0, empty=1.
- Burst ordering:
  - Stimulus: push 8'h11, 8'h22, 8'h33, 8'h44, 8'h55 back-to-back into the uart_top loopback (rx tied to tx).
  - Required: doutrx sequence is 11, 22, 33, 44, 55; exactly 5 newd assertions.
- Full/overflow:
  - Stimulus: with donetx held 0, push DEPTH+2=18 bytes.
  - Required: full=1 after the 16th queued byte; overflow=1; drop_cnt=1 when the macro is defined.
  - After donetx: the 16 accepted bytes are transmitted in order; wrap-around is correct.
- Simultaneous push/pop at full:
  - Stimulus: queue full, wr_en on the same edge as the IDLE→LAUNCH transition.
  - Required: push rejected, count becomes 15, overflow=1.
- Level-held donetx and gap, GAP_CYCLES=10:
  - Stimulus: hold donetx high for 50 cycles.
  - Required: only one byte advances; next newd rises 12 cycles after the donetx rising edge.
- Reset mid-operation:
  - Stimulus: assert rst in LAUNCH with 3 bytes queued.
  - Required: newd=0 and empty=1 in the same cycle (async); no further launches after deassert.

Source files
------------

// File: rtl/uart_tx_queue.sv
// uart_tx_queue
//   Circular byte FIFO that feeds a UART transmitter one byte at a time.
//   The host pushes bytes at the full clk rate. The FSM pops one byte and
//   raises newd for NEWD_CYCLES clocks, so the slower UART bit clock can
//   sample it. It then waits for a rising edge on donetx, and finally idles
//   for GAP_CYCLES clocks before the next launch.
//
// Parameters
//   DEPTH        FIFO entries (power of two, 2..256)
//   NEWD_CYCLES  clk cycles newd is held high per launch
//   GAP_CYCLES   idle clk cycles after each completion (0 = no gap state)
//
// Ports
//   clk       in   system clock
//   rst       in   asynchronous active-high reset (deassertion synchronised)
//   wr_en     in   host push strobe
//   wr_data   in   [7:0] host byte
//   full      out  FIFO holds DEPTH entries
//   empty     out  FIFO holds 0 entries
//   overflow  out  sticky: a push was attempted while full
//   busy      out  FSM not idle
//   dintx     out  [7:0] byte presented to the UART transmitter
//   newd      out  launch request to the UART transmitter
//   donetx    in   UART transmit-complete (level or pulse)
//   drop_cnt  out  [7:0] saturating count of rejected pushes
//                  (present only when UART_TXQ_DROP_CNT_EN is defined)
//
// Optional feature macro: UART_TXQ_DROP_CNT_EN
module uart_tx_queue #(
  parameter int DEPTH       = 16,
  parameter int NEWD_CYCLES = 104,
  parameter int GAP_CYCLES  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic       overflow,
  output logic       busy,
  output logic [7:0] dintx,
  output logic       newd,
  input  logic       donetx
`ifdef UART_TXQ_DROP_CNT_EN
  ,
  output logic [7:0] drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = (NEWD_CYCLES > 1) ? $clog2(NEWD_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [HW-1:0] HOLD_LAST = HW'(NEWD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LAUNCH    = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam logic [1:0] ST_GAP       = 2'd3;
  // Where to go once the transmitter reports completion.
  localparam logic [1:0] ST_AFTER_DONE = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

  // Reset synchroniser: assert immediately, release on a clock edge.
  logic [1:0] rst_pipe_reg;
  logic       arst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_pipe_reg <= 2'b11;
    else     rst_pipe_reg <= {rst_pipe_reg[0], 1'b0};
  end
  assign arst = rst_pipe_reg[1];

  // Storage and FIFO bookkeeping
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic          full_reg, empty_reg, overflow_reg;
  logic [7:0]    dintx_reg;

  // FSM
  logic [1:0]    state_reg, state_next;
  logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
  logic [GW-1:0] gap_cnt_reg, gap_cnt_next;
  logic          done_seen_reg, done_seen_next;
  logic          newd_reg, newd_next;
  logic          done_q_reg;

  logic push_ok, push_rej, pop, done_rise;

  // full is the registered value, so a push that coincides with a pop
  // while full is still rejected.
  assign push_ok   = wr_en & ~full_reg;
  assign push_rej  = wr_en & full_reg;
  assign pop       = (state_reg == ST_IDLE) & ~empty_reg;
  assign done_rise = donetx & ~done_q_reg;

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Write port without reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      full_reg     <= 1'b0;
      empty_reg    <= 1'b1;
      overflow_reg <= 1'b0;
      dintx_reg    <= 8'h00;
    end else begin
      count_reg <= count_next;
      full_reg  <= (count_next == COUNT_MAX);
      empty_reg <= (count_next == '0);
      if (push_ok)  wr_ptr_reg   <= wr_ptr_reg + AW'(1);
      if (push_rej) overflow_reg <= 1'b1;
      if (pop) begin
        // Registered read; dintx only ever changes on a launch.
        dintx_reg  <= mem[rd_ptr_reg];
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    hold_cnt_next  = hold_cnt_reg;
    gap_cnt_next   = gap_cnt_reg;
    done_seen_next = done_seen_reg;
    newd_next      = newd_reg;
    case (state_reg)
      ST_IDLE: begin
        if (pop) begin
          state_next     = ST_LAUNCH;
          hold_cnt_next  = '0;
          done_seen_next = 1'b0;
          newd_next      = 1'b1;
        end
      end
      ST_LAUNCH: begin
        // A fast transmitter may finish while newd is still held; remember it.
        if (done_rise) done_seen_next = 1'b1;
        if (hold_cnt_reg == HOLD_LAST) begin
          newd_next    = 1'b0;
          gap_cnt_next = '0;
          if (done_seen_reg | done_rise) state_next = ST_AFTER_DONE;
          else                           state_next = ST_WAIT_DONE;
        end else begin
          hold_cnt_next = hold_cnt_reg + HW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (done_rise) begin
          state_next   = ST_AFTER_DONE;
          gap_cnt_next = '0;
        end
      end
      ST_GAP: begin
        if (gap_cnt_reg == GAP_LAST) state_next = ST_IDLE;
        else                         gap_cnt_next = gap_cnt_reg + GW'(1);
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_reg     <= ST_IDLE;
      hold_cnt_reg  <= '0;
      gap_cnt_reg   <= '0;
      done_seen_reg <= 1'b0;
      newd_reg      <= 1'b0;
      done_q_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      hold_cnt_reg  <= hold_cnt_next;
      gap_cnt_reg   <= gap_cnt_next;
      done_seen_reg <= done_seen_next;
      newd_reg      <= newd_next;
      done_q_reg    <= donetx;
    end
  end

`ifdef UART_TXQ_DROP_CNT_EN
  logic [7:0] drop_cnt_reg;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      drop_cnt_reg <= 8'h00;
    end else if (push_rej && (drop_cnt_reg != 8'hFF)) begin
      drop_cnt_reg <= drop_cnt_reg + 8'd1;
    end
  end
  assign drop_cnt = drop_cnt_reg;
`endif

  assign full     = full_reg;
  assign empty    = empty_reg;
  assign overflow = overflow_reg;
  assign busy     = (state_reg != ST_IDLE);
  assign dintx    = dintx_reg;
  assign newd     = newd_reg;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Testbench for uart_tx_queue (DEPTH=16, NEWD_CYCLES=104, GAP_CYCLES=10).
// A behavioural transmitter responder answers each launch with a donetx pulse
// after a random delay. A monitor logs every launched byte and newd pulse length.
module tb_uart_tx_queue;

  localparam int DEPTH = 16;
  localparam int NEWD  = 104;
  localparam int GAP   = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       done_man = 1'b0;
  logic       done_auto = 1'b0;
  logic       donetx;
  logic       full, empty, overflow, busy, newd;
  logic [7:0] dintx;
`ifdef UART_TXQ_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  assign donetx = done_man | done_auto;

  uart_tx_queue #(.DEPTH(DEPTH), .NEWD_CYCLES(NEWD), .GAP_CYCLES(GAP)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .busy     (busy),
    .dintx    (dintx),
    .newd     (newd),
    .donetx   (donetx)
`ifdef UART_TXQ_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log every launch (byte on dintx) and the length of each newd pulse.
  logic [7:0] launched[$];
  int         lens[$];
  logic       newd_prev = 1'b0;
  int         start_cyc = 0;
  initial forever begin
    @(posedge clk);
    #2;
    if (newd && !newd_prev) begin
      launched.push_back(dintx);
      start_cyc = cyc;
    end
    if (!newd && newd_prev) lens.push_back(cyc - start_cyc);
    newd_prev = newd;
  end

  // Transmitter model: completion pulse at a random delay after each launch
  // (sometimes inside the newd hold, sometimes after it).
  bit auto_en = 1'b0;
  initial forever begin
    int d;
    @(posedge newd);
    if (auto_en) begin
      d = $urandom_range(10, 150);
      repeat (d) @(posedge clk);
      #1;
      if (auto_en) done_auto = 1'b1;
      @(posedge clk);
      #1;
      done_auto = 1'b0;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    auto_en = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(4);
    launched.delete();
    lens.delete();
  endtask

  task automatic push_burst(input logic [7:0] vals[$]);
    foreach (vals[i]) begin
      wr_en = 1'b1;
      wr_data = vals[i];
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (!(!busy && empty) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_drain_in_time"}, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_newd_low(input string tag);
    int n = 0;
    while (newd && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_newd_fall_in_time"}, 32'(n < 200), 32'd1);
  endtask

  task automatic check_seq(input string tag, input logic [7:0] exp_q[$]);
    check({tag, "_launch_count"}, 32'(launched.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < launched.size(); i++) begin
      $display("%s tx #%0d dintx=%02h model=%02h", tag, i, launched[i], exp_q[i]);
      check({tag, "_byte"}, 32'(launched[i]), 32'(exp_q[i]));
    end
    foreach (lens[i]) check({tag, "_newd_len"}, 32'(lens[i]), 32'(NEWD));
  endtask

  initial begin
    logic [7:0] vals[$];
    logic [7:0] exp_q[$];
    int n;

    // Reset state
    tick(3);
    check("rst_full", 32'(full), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dintx", 32'(dintx), 32'h00);
    check("rst_newd", 32'(newd), 32'd0);
`ifdef UART_TXQ_DROP_CNT_EN
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    do_reset();

    // Single byte: latency, hold length, gap after completion
    wr_en = 1'b1;
    wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    check("single_newd_not_yet", 32'(newd), 32'd0);
    check("single_empty_cleared", 32'(empty), 32'd0);
    tick();
    check("single_newd_rise", 32'(newd), 32'd1);
    check("single_dintx", 32'(dintx), 32'hA5);
    check("single_busy", 32'(busy), 32'd1);
    tick(NEWD - 1);
    check("single_newd_last_cycle", 32'(newd), 32'd1);
    tick();
    check("single_newd_dropped", 32'(newd), 32'd0);
    tick(20);
    check("single_wait_busy", 32'(busy), 32'd1);
    check("single_dintx_stable", 32'(dintx), 32'hA5);
    done_man = 1'b1;
    tick();
    done_man = 1'b0;
    tick(GAP - 1);
    check("single_gap_busy", 32'(busy), 32'd1);
    tick();
    check("single_idle_busy", 32'(busy), 32'd0);
    check("single_idle_empty", 32'(empty), 32'd1);
    exp_q = '{8'hA5};
    check_seq("single", exp_q);

    // Burst ordering with the responder running
    do_reset();
    auto_en = 1'b1;
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    push_burst(vals);
    wait_drain("burst", 2000);
    check_seq("burst", vals);

    // Random bursts with random spacing, never more than half full
    for (int r = 0; r < 4; r++) begin
      do_reset();
      auto_en = 1'b1;
      vals.delete();
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++) begin
        vals.push_back(8'($urandom_range(0, 255)));
        wr_en = 1'b1;
        wr_data = vals[k];
        tick();
        wr_en = 1'b0;
        tick($urandom_range(0, 3));
      end
      wait_drain("random", 3000);
      check_seq("random", vals);
    end

    // Full / overflow: 18 pushes, one goes straight into flight, 16 queue, 1 drops
    do_reset();
    vals.delete();
    for (int k = 0; k < DEPTH + 2; k++) begin
      vals.push_back(8'($urandom_range(0, 255)));
      wr_en = 1'b1;
      wr_data = vals[k];
      tick();
      if (k == DEPTH - 1) check("ovf_not_full_yet", 32'(full), 32'd0);
      if (k == DEPTH) begin
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_no_overflow_yet", 32'(overflow), 32'd0);
      end
    end
    wr_en = 1'b0;
    check("ovf_overflow", 32'(overflow), 32'd1);
    check("ovf_still_full", 32'(full), 32'd1);
`ifdef UART_TXQ_DROP_CNT_EN
    check("ovf_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
    wait_newd_low("ovf");
    auto_en = 1'b1;
    done_man = 1'b1;
    tick();
    done_man = 1'b0;
    wait_drain("ovf", 6000);
    exp_q = vals[0:DEPTH];
    check_seq("ovf", exp_q);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Push on the same edge as a pop while full: rejected
    do_reset();
    vals.delete();
    for (int k = 0; k < DEPTH + 1; k++) vals.push_back(8'($urandom_range(0, 255)));
    push_burst(vals);
    check("simul_full", 32'(full), 32'd1);
    check("simul_no_overflow", 32'(overflow), 32'd0);
    wait_newd_low("simul");
    done_man = 1'b1;
    tick();
    done_man = 1'b0;
    tick(GAP);
    check("simul_idle", 32'(busy), 32'd0);
    check("simul_full_at_pop", 32'(full), 32'd1);
    auto_en = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'hEE;
    tick();
    wr_en = 1'b0;
    check("simul_launch", 32'(newd), 32'd1);
    check("simul_overflow", 32'(overflow), 32'd1);
    check("simul_full_cleared", 32'(full), 32'd0);
`ifdef UART_TXQ_DROP_CNT_EN
    check("simul_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
    wait_drain("simul", 6000);
    check_seq("simul", vals);

    // Level-held donetx: only one byte advances; launch 12 cycles after the rise
    do_reset();
    vals = '{8'h3C, 8'hC3};
    push_burst(vals);
    wait_newd_low("level");
    done_man = 1'b1;
    tick();
    tick(GAP);
    check("level_gap_no_newd", 32'(newd), 32'd0);
    tick();
    check("level_next_newd", 32'(newd), 32'd1);
    check("level_next_dintx", 32'(dintx), 32'hC3);
    tick(38);
    done_man = 1'b0;
    tick(100);
    check("level_no_retrigger_newd", 32'(newd), 32'd0);
    check("level_waiting", 32'(busy), 32'd1);
    check("level_launches", 32'(launched.size()), 32'd2);
    done_man = 1'b1;
    tick();
    done_man = 1'b0;
    tick(GAP + 1);
    check("level_done_idle", 32'(busy), 32'd0);
    check_seq("level", vals);

    // Reset in the middle of a launch with 3 bytes queued
    do_reset();
    vals = '{8'h01, 8'h02, 8'h03, 8'h04};
    push_burst(vals);
    tick(5);
    check("midrst_launching", 32'(newd), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_newd_async", 32'(newd), 32'd0);
    check("midrst_empty_async", 32'(empty), 32'd1);
    check("midrst_busy_async", 32'(busy), 32'd0);
    tick(2);
    rst = 1'b0;
    launched.delete();
    lens.delete();
    tick(200);
    check("midrst_no_launch", 32'(launched.size()), 32'd0);
    check("midrst_empty", 32'(empty), 32'd1);
    check("midrst_overflow", 32'(overflow), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
